// File: rtl/bnn_acc_pkg.sv
// Shared defaults, saturation limits and FSM state type for the binarized
// accumulate/threshold/pack stage.
package bnn_acc_pkg;

  localparam int PROD_W_DEF = 12;
  localparam int ACC_W_DEF  = 16;
  localparam int PACK_W_DEF = 16;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = 16'sh7FFF;
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = 16'sh8000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/bnn_acc_thresh_sat_add.sv
// Combinational saturating adder: sign-extends the product, adds it to the
// accumulator and clamps the result to the signed accumulator range.
module bnn_sat_add #(
  parameter int PROD_W = 12,
  parameter int ACC_W  = 16
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic signed [ACC_W-1:0]  o_sum
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] w_wide;

  assign w_wide = {i_acc[ACC_W-1], i_acc}
                + {{(ACC_W+1-PROD_W){i_prod[PROD_W-1]}}, i_prod};

  // One guard bit is enough: overflow shows as the top two bits disagreeing.
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      o_sum = w_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/bnn_acc_thresh.sv
// Accumulates signed products per neuron, thresholds each neuron to one bit
// and packs bits into words with a one-deep output register and flush support.
module bnn_acc_thresh
  import bnn_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PACK_W = PACK_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prod_valid,
  output logic                      prod_ready,
  input  logic signed [PROD_W-1:0]  prod_data,
  input  logic                      prod_last,
  input  logic signed [ACC_W-1:0]   thresh,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PACK_W-1:0]         out_data,
  output logic [$clog2(PACK_W):0]   out_count,
  output state_t                    dbg_state
);

  localparam int CNT_W = $clog2(PACK_W) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_W);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never looks at valid, and the source holds its payload
  // stable while valid is high and ready is low.

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [PACK_W-1:0]        r_pack, w_pack_nxt;
  logic [CNT_W-1:0]         r_idx, w_idx_nxt;
  logic                     r_flush_pend, w_flush_pend_nxt;
  logic                     r_out_valid, w_out_valid_nxt;
  logic [PACK_W-1:0]        r_out_data, w_out_data_nxt;
  logic [CNT_W-1:0]         r_out_count, w_out_count_nxt;

  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_out_free, w_acc_beat, w_last_beat, w_bit;
  logic                     w_hold_xfer, w_flush_eff, w_full, w_emit_req;
  logic [PACK_W-1:0]        w_base_pack, w_new_pack;
  logic [CNT_W-1:0]         w_base_idx, w_new_idx;

  bnn_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_sat_add (
    .i_acc  (r_acc),
    .i_prod (prod_data),
    .o_sum  (w_sum)
  );

  assign w_out_free  = !r_out_valid || out_ready;
  assign prod_ready  = w_out_free || (r_state == RUN);
  assign w_acc_beat  = prod_valid && prod_ready;
  assign w_last_beat = w_acc_beat && prod_last;
  assign w_bit       = (w_sum >= thresh);

  // Leaving HOLD moves the pending full word out, so new bits start at zero.
  assign w_hold_xfer = (r_state == HOLD) && out_ready;
  assign w_base_pack = w_hold_xfer ? '0 : r_pack;
  assign w_base_idx  = w_hold_xfer ? '0 : r_idx;
  assign w_new_pack  = w_base_pack | (PACK_W'(w_last_beat && w_bit) << w_base_idx);
  assign w_new_idx   = w_base_idx + CNT_W'(w_last_beat);

  assign w_flush_eff = flush || r_flush_pend;
  assign w_full      = (w_new_idx == FULL_CNT);
  assign w_emit_req  = w_full || (w_flush_eff && (w_new_idx != '0));

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_pack_nxt       = r_pack;
    w_idx_nxt        = r_idx;
    w_flush_pend_nxt = r_flush_pend;
    w_out_valid_nxt  = r_out_valid && !out_ready;
    w_out_data_nxt   = r_out_data;
    w_out_count_nxt  = r_out_count;

    if (w_acc_beat) begin
      w_acc_nxt = prod_last ? '0 : w_sum;
    end

    case (r_state)
      RUN: begin
        if (w_emit_req && w_out_free) begin
          w_out_valid_nxt  = 1'b1;
          w_out_data_nxt   = w_new_pack;
          w_out_count_nxt  = w_new_idx;
          w_pack_nxt       = '0;
          w_idx_nxt        = '0;
          w_flush_pend_nxt = 1'b0;
        end else if (w_full) begin
          w_state_nxt      = HOLD;
          w_pack_nxt       = w_new_pack;
          w_idx_nxt        = w_new_idx;
          w_flush_pend_nxt = 1'b0;
        end else begin
          w_pack_nxt       = w_new_pack;
          w_idx_nxt        = w_new_idx;
          w_flush_pend_nxt = w_flush_eff && !w_out_free;
        end
      end
      HOLD: begin
        // The pending full word already covers every bit, so flush is absorbed
        // until the word moves into the output register.
        w_flush_pend_nxt = 1'b0;
        if (out_ready) begin
          w_state_nxt      = RUN;
          w_out_valid_nxt  = 1'b1;
          w_out_data_nxt   = r_pack;
          w_out_count_nxt  = FULL_CNT;
          w_pack_nxt       = w_new_pack;
          w_idx_nxt        = w_new_idx;
          w_flush_pend_nxt = flush;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_acc        <= '0;
      r_pack       <= '0;
      r_idx        <= '0;
      r_flush_pend <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_pack       <= w_pack_nxt;
      r_idx        <= w_idx_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_count  <= w_out_count_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bnn_acc_thresh.sv
// Directed bench for bnn_acc_thresh: packing, saturation, flush, backpressure
// and reset recovery with hand-computed expected words.
module tb_bnn_acc_thresh;
  import bnn_acc_pkg::*;

  localparam int PW = 12;
  localparam int AW = 16;
  localparam int KW = 16;
  localparam int CW = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 prod_valid = 1'b0;
  logic                 prod_ready;
  logic signed [PW-1:0] prod_data = '0;
  logic                 prod_last = 1'b0;
  logic signed [AW-1:0] thresh = '0;
  logic                 flush = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [KW-1:0]        out_data;
  logic [CW-1:0]        out_count;
  state_t               dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW+KW-1:0] got_q[$];

  bnn_acc_thresh #(.PROD_W(PW), .ACC_W(AW), .PACK_W(KW)) dut (
    .clk        (clk),
    .reset      (reset),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .thresh     (thresh),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back({out_count, out_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_beat(input int val, input bit last, input int th, input bit fl);
    int t;
    t = 0;
    prod_valid = 1'b1;
    prod_data  = PW'(val);
    prod_last  = last;
    thresh     = AW'(th);
    flush      = fl;
    #1;
    while (!prod_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (!prod_ready) begin
      n_checks++;
      $display("FAIL beat_accept_timeout: prod_ready=%0b want 1", prod_ready);
    end
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic send_neuron(input int val, input int nbeats, input int th, input bit fl);
    for (int b = 0; b < nbeats; b++) send_beat(val, (b == nbeats - 1), th, fl && (b == nbeats - 1));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd0) $display("FAIL reset_out_count: got %0d want 0", out_count); else n_pass++;
    n_checks++; if (prod_ready !== 1'b1) $display("FAIL reset_prod_ready: got %0b want 1", prod_ready); else n_pass++;
    n_checks++; if (dbg_state !== RUN) $display("FAIL reset_state: got %0d want RUN", dbg_state); else n_pass++;
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    got_q.delete();
    for (int n = 0; n < 15; n++) send_neuron(10, 4, 40, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL full_early_valid: got %0b want 0", out_valid); else n_pass++;
    send_neuron(10, 4, 40, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL full_valid: got %0b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'hFFFF) $display("FAIL full_data: got %h want ffff", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd16) $display("FAIL full_count: got %0d want 16", out_count); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL full_drop: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (got_q.size() != 1) $display("FAIL full_words: got %0d want 1", got_q.size()); else n_pass++;
  endtask

  task automatic test_saturation();
    send_neuron(2047, 20, 32767, 1'b0);
    send_neuron(-2048, 20, -32768, 1'b0);
    send_neuron(-2048, 20, -32767, 1'b0);
    pulse_flush();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL sat_valid: got %0b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0003) $display("FAIL sat_data: got %h want 0003", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd3) $display("FAIL sat_count: got %0d want 3", out_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_alternating();
    send_neuron(5, 1, 6, 1'b0);
    send_neuron(3, 2, 6, 1'b0);
    send_neuron(5, 1, 6, 1'b0);
    pulse_flush();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL alt_valid: got %0b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0002) $display("FAIL alt_data: got %h want 0002", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd3) $display("FAIL alt_count: got %0d want 3", out_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flush_cases();
    // Flush on the same beat as a last product includes that bit.
    send_neuron(1, 1, 0, 1'b0);
    send_neuron(1, 2, 3, 1'b1);
    n_checks++; if (out_data !== 16'h0001) $display("FAIL flush_last_data: got %h want 0001", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd2) $display("FAIL flush_last_count: got %0d want 2", out_count); else n_pass++;
    @(negedge clk);
    pulse_flush();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_empty_valid: got %0b want 0", out_valid); else n_pass++;
    // Flush during a neuron leaves the accumulator alone.
    send_neuron(1, 1, 0, 1'b0);
    send_beat(7, 1'b0, 0, 1'b1);
    n_checks++; if (out_count !== 5'd1) $display("FAIL flush_mid_count: got %0d want 1", out_count); else n_pass++;
    send_beat(3, 1'b1, 10, 1'b0);
    pulse_flush();
    n_checks++; if (out_data !== 16'h0001) $display("FAIL flush_mid_acc_data: got %h want 0001", out_data); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    got_q.delete();
    for (int n = 0; n < 16; n++) send_neuron(1, 1, (n % 2 == 0) ? 1 : 2, 1'b0);
    n_checks++; if (out_data !== 16'h5555) $display("FAIL b2b_first_data: got %h want 5555", out_data); else n_pass++;
    for (int n = 0; n < 16; n++) send_neuron(1, 1, (n % 2 == 1) ? 1 : 2, 1'b0);
    n_checks++; if (dbg_state !== HOLD) $display("FAIL b2b_hold_state: got %0d want HOLD", dbg_state); else n_pass++;
    n_checks++; if (prod_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %0b want 0", prod_ready); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (out_data !== 16'h5555) $display("FAIL b2b_stable_data: got %h want 5555", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd16) $display("FAIL b2b_stable_count: got %0d want 16", out_count); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_data !== 16'hAAAA) $display("FAIL b2b_second_data: got %h want aaaa", out_data); else n_pass++;
    n_checks++; if (dbg_state !== RUN) $display("FAIL b2b_run_state: got %0d want RUN", dbg_state); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drop: got %0b want 0", out_valid); else n_pass++;
    n_checks++;
    if (got_q.size() != 2) $display("FAIL b2b_words: got %0d want 2", got_q.size());
    else if (got_q[0] !== {5'd16, 16'h5555} || got_q[1] !== {5'd16, 16'hAAAA})
      $display("FAIL b2b_order: got %h,%h want %h,%h", got_q[0], got_q[1], {5'd16, 16'h5555}, {5'd16, 16'hAAAA});
    else n_pass++;
  endtask

  task automatic test_flush_busy();
    logic [4:0] pat;
    pat = 5'b01101;
    out_ready = 1'b0;
    got_q.delete();
    for (int n = 0; n < 16; n++) send_neuron(10, 1, 10, 1'b0);
    for (int n = 0; n < 5; n++) send_neuron(10, 1, pat[n] ? 10 : 11, 1'b0);
    pulse_flush();
    n_checks++; if (out_data !== 16'hFFFF) $display("FAIL fbusy_held_data: got %h want ffff", out_data); else n_pass++;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL fbusy_valid: got %0b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h000D) $display("FAIL fbusy_data: got %h want 000d", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd5) $display("FAIL fbusy_count: got %0d want 5", out_count); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (got_q.size() != 2) $display("FAIL fbusy_words: got %0d want 2", got_q.size());
    else if (got_q[0] !== {5'd16, 16'hFFFF} || got_q[1] !== {5'd5, 16'h000D})
      $display("FAIL fbusy_order: got %h,%h want %h,%h", got_q[0], got_q[1], {5'd16, 16'hFFFF}, {5'd5, 16'h000D});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int n = 0; n < 7; n++) send_neuron(10, 1, 10, 1'b0);
    send_beat(-100, 1'b0, 0, 1'b0);
    send_beat(-100, 1'b0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b want 0", out_valid); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    got_q.delete();
    for (int n = 0; n < 16; n++) send_neuron(10, 1, 10, 1'b0);
    n_checks++; if (out_data !== 16'hFFFF) $display("FAIL rmid_data: got %h want ffff", out_data); else n_pass++;
    n_checks++; if (out_count !== 5'd16) $display("FAIL rmid_count: got %0d want 16", out_count); else n_pass++;
    @(negedge clk);
    n_checks++; if (got_q.size() != 1) $display("FAIL rmid_words: got %0d want 1", got_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_saturation();
    test_alternating();
    test_flush_cases();
    test_back_to_back();
    test_flush_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
